// File: rtl/instr_fetch_unit_if.sv
// Decode-side handshake of the fetch stage.
// The fetch unit is the master; decode is the slave.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int ISIZE  = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [ISIZE-1:0]  out_instr;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, tags returning I-mem words with their PC
// and buffers them in a small shift FIFO towards decode.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                ISIZE     = 16,
  parameter int                DEPTH     = 2,
  parameter int                START_DLY = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ISIZE-1:0]  imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted,
  instr_fetch_unit_if.master dec
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam logic [CW:0]   DEP      = (CW + 1)'(DEPTH);
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DLY - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_HALT
  } state_t;

  state_t            state, state_n;
  logic [DW-1:0]     dly, dly_n;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [CW-1:0]     count, count_n;
  logic [ADDR_W-1:0] pc_q  [DEPTH];
  logic [ISIZE-1:0]  ins_q [DEPTH];
  logic [ADDR_W-1:0] pc_n  [DEPTH];
  logic [ISIZE-1:0]  ins_n [DEPTH];
  logic [CW:0]       occ;
  logic [IW-1:0]     widx;
  logic              redir, pop, push, issue;

  // Redirects are ignored until the memory has finished its start-up delay.
  assign redir = redirect & (state != S_WAIT);
  assign pop   = dec.out_valid & dec.out_ready;
  assign push  = inflight & ~redir;
  assign occ   = {1'b0, count} + (CW + 1)'(inflight);
  assign issue = (state == S_RUN) & ~halt_req & ~redir
               & (occ < DEP + (CW + 1)'(pop));

  assign imem_addr     = pc;
  assign halted        = (state == S_HALT) & ~inflight;
  assign dec.out_valid = (count != '0);
  assign dec.out_pc    = pc_q[0];
  assign dec.out_instr = ins_q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_WAIT;
      dly   <= '0;
    end else begin
      state <= state_n;
      dly   <= dly_n;
    end
  end

  always_comb begin
    state_n = state;
    dly_n   = dly;
    unique case (state)
      S_WAIT: begin
        if (dly == DLY_LAST) state_n = S_RUN;
        else                 dly_n   = dly + 1'b1;
      end
      S_RUN:   if (halt_req)  state_n = S_HALT;
      S_HALT:  if (!halt_req) state_n = S_RUN;
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (redir) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight_pc <= pc;
      end
    end
  end

  // Entry 0 is the head, so the output fields come straight from flops.
  always_comb begin
    pc_n    = pc_q;
    ins_n   = ins_q;
    widx    = IW'(count - CW'(pop));
    count_n = count + CW'(push) - CW'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        pc_n[i]  = pc_q[i+1];
        ins_n[i] = ins_q[i+1];
      end
    end
    if (push) begin
      pc_n[widx]  = inflight_pc;
      ins_n[widx] = imem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else if (redir) begin
      count <= '0;
    end else begin
      count <= count_n;
      pc_q  <= pc_n;
      ins_q <= ins_n;
    end
  end

endmodule
